// File: rtl/alu_seq.sv
// alu_seq: execute-stage ALU with valid/ready handshake, persistent Z/N/C flags and a serial
// one-bit-per-cycle shifter for SHL/SHR. Define ALU_OVERFLOW_FLAG_EN to add the signed overflow flag V.
module alu_seq #(
   parameter int WIDTH = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [2:0]       i_op,
   input  logic [WIDTH-1:0] i_data_1,
   input  logic [WIDTH-1:0] i_data_2,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_result,
   output logic             o_zero_flag,
   output logic             o_negative_flag,
   output logic             o_carry_flag,
`ifdef ALU_OVERFLOW_FLAG_EN
   output logic             o_overflow_flag,
   input  logic [3:0]       i_flag_data,
`else
   input  logic [2:0]       i_flag_data,
`endif
   input  logic             i_flag_load
);

   localparam int SHAMT_W = $clog2(WIDTH + 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam logic [2:0] OP_MOV = 3'b000;
   localparam logic [2:0] OP_NOT = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;
   localparam logic [2:0] OP_AND = 3'b100;
   localparam logic [2:0] OP_OR  = 3'b101;
   localparam logic [2:0] OP_SHL = 3'b110;
   localparam logic [2:0] OP_SHR = 3'b111;

   localparam logic [SHAMT_W-1:0] CNT_ZERO = SHAMT_W'(0);
   localparam logic [SHAMT_W-1:0] CNT_ONE  = SHAMT_W'(1);
   localparam logic [SHAMT_W-1:0] CNT_FULL = SHAMT_W'(WIDTH);
   localparam logic [WIDTH-1:0]   B_FULL   = WIDTH'(WIDTH);
   localparam logic [WIDTH-1:0]   DATA_ZERO = {WIDTH{1'b0}};

   logic [1:0]         state_q, state_d;
   logic [SHAMT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0]   sh_q, sh_d;
   logic               sh_left_q, sh_left_d;
   logic               sh_c_q, sh_c_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               z_q, z_d, n_q, n_d, c_q, c_d;
   logic               valid_q, valid_d;

   logic               accept_s, is_shift_s, load_alu_s, load_sh_s;
   logic [WIDTH:0]     sum_s, diff_s;
   logic [WIDTH-1:0]   alu_res_s;
   logic               alu_c_s, alu_zn_upd_s;
   logic [SHAMT_W-1:0] sh_amt_s;

`ifdef ALU_OVERFLOW_FLAG_EN
   logic v_q, v_d, alu_v_s;
   assign o_overflow_flag = v_q;
`endif

   assign o_ready    = i_rst_n & (state_q == ST_IDLE) & (~valid_q | i_ready);
   assign accept_s   = i_valid & o_ready;
   assign is_shift_s = (i_op == OP_SHL) | (i_op == OP_SHR);
   assign load_alu_s = accept_s & ~is_shift_s;
   assign load_sh_s  = (state_q == ST_DONE);
   assign sum_s      = {1'b0, i_data_1} + {1'b0, i_data_2};
   assign diff_s     = {1'b0, i_data_1} - {1'b0, i_data_2};
   assign sh_amt_s   = (i_data_2 >= B_FULL) ? CNT_FULL : i_data_2[SHAMT_W-1:0];

   // Single-cycle operations; the borrow of A-B is the top bit of the widened difference
   always_comb begin
      alu_res_s    = i_data_1;
      alu_c_s      = c_q;
      alu_zn_upd_s = 1'b1;
`ifdef ALU_OVERFLOW_FLAG_EN
      alu_v_s      = v_q;
`endif
      case (i_op)
         OP_MOV: alu_zn_upd_s = 1'b0;
         OP_NOT: alu_res_s = ~i_data_1;
         OP_ADD: begin
            alu_res_s = sum_s[WIDTH-1:0];
            alu_c_s   = sum_s[WIDTH];
`ifdef ALU_OVERFLOW_FLAG_EN
            alu_v_s   = (i_data_1[WIDTH-1] == i_data_2[WIDTH-1]) &
                        (sum_s[WIDTH-1] != i_data_1[WIDTH-1]);
`endif
         end
         OP_SUB: begin
            alu_res_s = diff_s[WIDTH-1:0];
            alu_c_s   = diff_s[WIDTH];
`ifdef ALU_OVERFLOW_FLAG_EN
            alu_v_s   = (i_data_1[WIDTH-1] != i_data_2[WIDTH-1]) &
                        (diff_s[WIDTH-1] != i_data_1[WIDTH-1]);
`endif
         end
         OP_AND: alu_res_s = i_data_1 & i_data_2;
         OP_OR:  alu_res_s = i_data_1 | i_data_2;
         default: alu_res_s = i_data_1;
      endcase
   end

   // Shifter FSM: a count of zero skips SHIFT and goes straight to DONE
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sh_d      = sh_q;
      sh_left_d = sh_left_q;
      sh_c_d    = sh_c_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s & is_shift_s) begin
               sh_d      = i_data_1;
               cnt_d     = sh_amt_s;
               sh_c_d    = 1'b0;
               sh_left_d = (i_op == OP_SHL);
               state_d   = (sh_amt_s == CNT_ZERO) ? ST_DONE : ST_SHIFT;
            end else begin
               state_d   = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (sh_left_q) begin
               sh_c_d = sh_q[WIDTH-1];
               sh_d   = {sh_q[WIDTH-2:0], 1'b0};
            end else begin
               sh_c_d = sh_q[0];
               sh_d   = {1'b0, sh_q[WIDTH-1:1]};
            end
            cnt_d   = cnt_q - CNT_ONE;
            state_d = (cnt_q == CNT_ONE) ? ST_DONE : ST_SHIFT;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Output register: loads on a result, flag load overrides flags, valid drops on consume
   always_comb begin
      result_d = result_q;
      z_d      = z_q;
      n_d      = n_q;
      c_d      = c_q;
`ifdef ALU_OVERFLOW_FLAG_EN
      v_d      = v_q;
`endif
      if (load_alu_s) begin
         result_d = alu_res_s;
         c_d      = alu_c_s;
`ifdef ALU_OVERFLOW_FLAG_EN
         v_d      = alu_v_s;
`endif
         if (alu_zn_upd_s) begin
            z_d = (alu_res_s == DATA_ZERO);
            n_d = alu_res_s[WIDTH-1];
         end else begin
            z_d = z_q;
            n_d = n_q;
         end
      end else if (load_sh_s) begin
         result_d = sh_q;
         z_d      = (sh_q == DATA_ZERO);
         n_d      = sh_q[WIDTH-1];
         c_d      = sh_c_q;
      end else begin
         result_d = result_q;
      end
      if (i_flag_load) begin
`ifdef ALU_OVERFLOW_FLAG_EN
         {z_d, n_d, c_d, v_d} = i_flag_data;
`else
         {z_d, n_d, c_d} = i_flag_data;
`endif
      end else begin
         z_d = z_d;
      end
      if (load_alu_s | load_sh_s) begin
         valid_d = 1'b1;
      end else if (i_ready) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // State and output registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= CNT_ZERO;
         sh_q      <= DATA_ZERO;
         sh_left_q <= 1'b0;
         sh_c_q    <= 1'b0;
         result_q  <= DATA_ZERO;
         z_q       <= 1'b0;
         n_q       <= 1'b0;
         c_q       <= 1'b0;
         valid_q   <= 1'b0;
`ifdef ALU_OVERFLOW_FLAG_EN
         v_q       <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sh_q      <= sh_d;
         sh_left_q <= sh_left_d;
         sh_c_q    <= sh_c_d;
         result_q  <= result_d;
         z_q       <= z_d;
         n_q       <= n_d;
         c_q       <= c_d;
         valid_q   <= valid_d;
`ifdef ALU_OVERFLOW_FLAG_EN
         v_q       <= v_d;
`endif
      end
   end

   assign o_valid         = valid_q;
   assign o_result        = result_q;
   assign o_zero_flag     = z_q;
   assign o_negative_flag = n_q;
   assign o_carry_flag    = c_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq (WIDTH=16) against an arithmetic reference model.
module tb_alu_seq;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         i_valid = 1'b0;
   logic         o_ready;
   logic [2:0]   i_op = 3'd0;
   logic [W-1:0] i_data_1 = 16'd0;
   logic [W-1:0] i_data_2 = 16'd0;
   logic         o_valid;
   logic         i_ready = 1'b1;
   logic [W-1:0] o_result;
   logic         o_zero_flag, o_negative_flag, o_carry_flag;
   logic         i_flag_load = 1'b0;
`ifdef ALU_OVERFLOW_FLAG_EN
   logic         o_overflow_flag;
   logic [3:0]   i_flag_data = 4'd0;
`else
   logic [2:0]   i_flag_data = 3'd0;
`endif

   int checks_cnt = 0;
   int errors_cnt = 0;
   bit exp_z = 1'b0, exp_n = 1'b0, exp_c = 1'b0;

   alu_seq #(.WIDTH(W)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready), .i_op(i_op),
      .i_data_1(i_data_1), .i_data_2(i_data_2), .o_valid(o_valid), .i_ready(i_ready),
      .o_result(o_result), .o_zero_flag(o_zero_flag), .o_negative_flag(o_negative_flag),
      .o_carry_flag(o_carry_flag),
`ifdef ALU_OVERFLOW_FLAG_EN
      .o_overflow_flag(o_overflow_flag),
`endif
      .i_flag_data(i_flag_data), .i_flag_load(i_flag_load)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input longint act, input longint exp);
      checks_cnt++;
      if (act != exp) begin
         errors_cnt++;
         $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_flags(input string tag);
      check({tag, "_z"}, longint'(o_zero_flag), longint'(exp_z));
      check({tag, "_n"}, longint'(o_negative_flag), longint'(exp_n));
      check({tag, "_c"}, longint'(o_carry_flag), longint'(exp_c));
   endtask

   // Reference model: result, flag update and cycles-to-valid straight from the op definitions
   task automatic ref_model(input int op, input longint a, input longint b,
                            output longint r, output int lat);
      longint m = 65536;
      lat = 1;
      r = a;
      case (op)
         0: r = a;
         1: r = (m - 1) - a;
         2: begin r = (a + b) % m; exp_c = ((a + b) >= m); end
         3: begin r = (a - b + m) % m; exp_c = (a < b); end
         4: r = a & b;
         5: r = a | b;
         6: begin
            if (b >= 16) begin r = 0; exp_c = (a % 2) == 1; end
            else begin
               r = (a * (longint'(1) << b)) % m;
               exp_c = (b == 0) ? 1'b0 : ((a >> (16 - b)) % 2) == 1;
            end
            lat = ((b >= 16) ? 16 : int'(b)) + 2;
         end
         default: begin
            if (b >= 16) begin r = 0; exp_c = (a >> 15) == 1; end
            else begin
               r = a >> b;
               exp_c = (b == 0) ? 1'b0 : ((a >> (b - 1)) % 2) == 1;
            end
            lat = ((b >= 16) ? 16 : int'(b)) + 2;
         end
      endcase
      if (op != 0) begin
         exp_z = (r == 0);
         exp_n = (r >= 32768);
      end
   endtask

   // Issue one op with i_ready=1 and check latency, busy o_ready, result and flags
   task automatic run_op(input string tag, input int op, input int a, input int b);
      longint r;
      int lat_exp, lat, waited;
      waited = 0;
      i_ready = 1'b1;
      i_valid = 1'b0;
      #1;
      while (!o_ready && waited < 50) begin tick(); waited++; end
      check({tag, "_rdy"}, longint'(o_ready), 1);
      i_valid = 1'b1; i_op = 3'(op); i_data_1 = 16'(a); i_data_2 = 16'(b);
      tick();
      i_valid = 1'b0;
      ref_model(op, longint'(a), longint'(b), r, lat_exp);
      lat = 1;
      while (!o_valid && lat < 40) begin
         check({tag, "_busy"}, longint'(o_ready), 0);
         tick();
         lat++;
      end
      check({tag, "_lat"}, lat, lat_exp);
      check({tag, "_res"}, longint'(o_result), r);
      check_flags(tag);
   endtask

   initial begin
      longint r;
      int lat;
      // Reset state
      #2;
      check("rst_ready", longint'(o_ready), 0);
      check("rst_valid", longint'(o_valid), 0);
      check("rst_res", longint'(o_result), 0);
      check_flags("rst");
      tick(); tick();
      rst_n = 1'b1;
      #1;
      check("post_rst_ready", longint'(o_ready), 1);

      run_op("add_wrap", 2, 16'hFFFF, 16'h0001);
      check("add_wrap_c", longint'(o_carry_flag), 1);
      run_op("sub_borrow", 3, 16'h0003, 16'h0005);
      check("sub_borrow_res", longint'(o_result), 16'hFFFE);
      run_op("and_keepc", 4, 16'h00FF, 16'h0F0F);
      check("and_keepc_c", longint'(o_carry_flag), 1);
      run_op("mov_keep", 0, 16'h0000, 16'h1234);
      run_op("not", 1, 16'h00FF, 16'h0000);
      run_op("shl5", 6, 16'h8888, 5);
      check("shl5_res", longint'(o_result), 16'h1100);
      run_op("shr0", 7, 16'h0003, 0);
      run_op("shl16", 6, 16'h0001, 16);
      run_op("shr_big", 7, 16'h8001, 40);

      // Backpressure: held result, stalled second op accepted on the drain edge
      i_ready = 1'b1; tick();
      i_ready = 1'b0; i_valid = 1'b1; i_op = 3'd2; i_data_1 = 16'h00F0; i_data_2 = 16'h0F10;
      #1;
      check("bp_rdy0", longint'(o_ready), 1);
      tick();
      ref_model(2, 64'h00F0, 64'h0F10, r, lat);
      check("bp_valid", longint'(o_valid), 1);
      check("bp_res", longint'(o_result), 16'h1000);
      i_op = 3'd5; i_data_1 = 16'h0F00; i_data_2 = 16'h00F0;
      #1;
      check("bp_stall_rdy", longint'(o_ready), 0);
      tick(); tick();
      check("bp_hold_res", longint'(o_result), 16'h1000);
      check("bp_hold_valid", longint'(o_valid), 1);
      check("bp_hold_rdy", longint'(o_ready), 0);
      i_ready = 1'b1;
      #1;
      check("bp_drain_rdy", longint'(o_ready), 1);
      tick();
      i_valid = 1'b0;
      ref_model(5, 64'h0F00, 64'h00F0, r, lat);
      check("bp_second_res", longint'(o_result), 16'h0FF0);
      check("bp_second_valid", longint'(o_valid), 1);
      check_flags("bp_second");

      // Flag load wins over the ADD flag update on the same edge
      i_valid = 1'b1; i_op = 3'd2; i_data_1 = 16'h1234; i_data_2 = 16'h1111;
      i_flag_load = 1'b1; i_flag_data = 3'b010;
      tick();
      i_valid = 1'b0; i_flag_load = 1'b0;
      exp_z = 1'b0; exp_n = 1'b1; exp_c = 1'b0;
      check("fl_res", longint'(o_result), 16'h2345);
      check_flags("fl");

      // Reset in the middle of a shift
      i_valid = 1'b1; i_op = 3'd6; i_data_1 = 16'h8888; i_data_2 = 16'd5;
      tick();
      i_valid = 1'b0;
      tick(); tick();
      rst_n = 1'b0;
      #1;
      exp_z = 1'b0; exp_n = 1'b0; exp_c = 1'b0;
      check("mrst_res", longint'(o_result), 0);
      check("mrst_valid", longint'(o_valid), 0);
      check("mrst_rdy", longint'(o_ready), 0);
      check_flags("mrst");
      tick();
      rst_n = 1'b1;
      #1;
      check("mrst_rel_rdy", longint'(o_ready), 1);
      for (int k = 0; k < 8; k++) begin
         tick();
         check("mrst_idle_valid", longint'(o_valid), 0);
      end
      run_op("mrst_add", 2, 16'h7FFF, 16'h0001);

      // Randomized ops with occasional idle-cycle flag loads
      for (int t = 0; t < 60; t++) begin
         int op, a, b;
         op = int'($urandom_range(0, 7));
         a = int'($urandom_range(0, 65535));
         b = (op >= 6) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 65535));
         run_op("rnd", op, a, b);
         if ($urandom_range(0, 3) == 0) begin
            i_flag_load = 1'b1;
            i_flag_data = 3'($urandom_range(0, 7));
            tick();
            i_flag_load = 1'b0;
            exp_z = i_flag_data[2]; exp_n = i_flag_data[1]; exp_c = i_flag_data[0];
            check_flags("rnd_fl");
            check("rnd_fl_valid", longint'(o_valid), 0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
      $finish;
   end

endmodule
